wired_bus_rx: RTL and testbench

Receiver for the team's single-wire, open-drain signalling bus. Transmitters drive the line with (strong0, highz1), and a pull1 keeper holds it high when idle. This block samples the resolved line, synchronises and glitch-filters it, and decodes low-pulse widths into bits (short = 1, long = 0, very long = bus reset). It assembles the bits LSB-first into bytes and presents each byte on a valid/ready output. It is the receiving end of the transmitter the team builds on the same net.

---
 rtl/wired_bus_pkg.sv | 45 ++++
 rtl/wired_bus_filter.sv | 51 +++++
 rtl/wired_bus_rx.sv | 145 ++++++++++++++
 tb/tb_wired_bus_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wired_bus_pkg.sv
// Shared definitions for the single-wire open-drain bus: receiver FSM states,
// bit classes, default pulse timing and the width classifier.
package wired_bus_pkg;

    typedef enum logic {
        IDLE,
        LOW
    } rx_state_e;

    typedef enum logic [1:0] {
        BIT0,
        BIT1,
        RST,
        ERR
    } bit_class_e;

    localparam int DEF_FILT       = 3;
    localparam int DEF_T_MIN      = 4;
    localparam int DEF_T_ONE_MAX  = 15;
    localparam int DEF_T_ZERO_MAX = 60;
    localparam int DEF_T_RST_MIN  = 120;

    // Map a low-pulse width in clocks onto a bit class.
    function automatic bit_class_e classify_width(
        input int unsigned w,
        input int unsigned t_min,
        input int unsigned t_one_max,
        input int unsigned t_zero_max,
        input int unsigned t_rst_min
    );
        bit_class_e cls;
        if (w < t_min)
            cls = ERR;
        else if (w <= t_one_max)
            cls = BIT1;
        else if (w <= t_zero_max)
            cls = BIT0;
        else if (w < t_rst_min)
            cls = ERR;
        else
            cls = RST;
        return cls;
    endfunction

endpackage

// File: rtl/wired_bus_filter.sv
// Two-flop synchroniser plus glitch filter for the asynchronous bus line.
// The filtered level only follows after FILT consecutive differing samples.
module wired_bus_filter
    import wired_bus_pkg::*;
#(
    parameter int FILT = DEF_FILT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bus_in,
    output logic filt_line
);

    localparam int RUN_W = $clog2(FILT + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q, filt_d;
    logic [RUN_W-1:0] run_q, run_d;

    always_comb begin
        sync1_d = bus_in;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        run_d   = '0;
        // The run length restarts whenever the sample agrees with the filtered level.
        if (sync2_q != filt_q) begin
            if (run_q == RUN_W'(FILT - 1))
                filt_d = sync2_q;
            else
                run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            run_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            run_q   <= run_d;
        end
    end

    assign filt_line = filt_q;

endmodule

// File: rtl/wired_bus_rx.sv
// Wired-bus receiver: measures low-pulse widths, decodes bits LSB-first into
// bytes and offers them on a valid/ready port with error/reset/overrun pulses.
module wired_bus_rx
    import wired_bus_pkg::*;
#(
    parameter int FILT       = DEF_FILT,
    parameter int T_MIN      = DEF_T_MIN,
    parameter int T_ONE_MAX  = DEF_T_ONE_MAX,
    parameter int T_ZERO_MAX = DEF_T_ZERO_MAX,
    parameter int T_RST_MIN  = DEF_T_RST_MIN,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bus_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       reset_det,
    output logic       err_timing,
    output logic       overrun
);

    if (((2 ** CNT_W) - 1 < T_RST_MIN) || (T_MIN > T_ONE_MAX) ||
        (T_ONE_MAX >= T_ZERO_MAX) || (T_ZERO_MAX >= T_RST_MIN)) begin : g_param_check
        $error("wired_bus_rx: inconsistent timing parameters");
    end

    logic filt_line;

    wired_bus_filter #(.FILT(FILT)) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_in   (bus_in),
        .filt_line(filt_line)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             reset_det_q, reset_det_d;
    logic             err_timing_q, err_timing_d;
    logic             overrun_q, overrun_d;

    bit_class_e cls;
    logic [7:0] shifted;
    logic       accept;

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        reset_det_d  = 1'b0;
        err_timing_d = 1'b0;
        overrun_d    = 1'b0;

        accept  = data_valid_q && data_ready;
        cls     = classify_width(32'(width_q), T_MIN, T_ONE_MAX, T_ZERO_MAX, T_RST_MIN);
        shifted = {(cls == BIT1), shreg_q[7:1]};

        if (accept)
            data_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!filt_line) begin
                    state_d = LOW;
                    width_d = CNT_W'(1);
                end
            end
            LOW: begin
                if (filt_line) begin
                    state_d = IDLE;
                    case (cls)
                        BIT0, BIT1: begin
                            shreg_d = shifted;
                            if (bit_cnt_q == 3'd7) begin
                                bit_cnt_d = 3'd0;
                                // A byte landing on an accept cycle replaces the old one.
                                if (!data_valid_q || accept) begin
                                    data_out_d   = shifted;
                                    data_valid_d = 1'b1;
                                end else begin
                                    overrun_d = 1'b1;
                                end
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                        RST: begin
                            reset_det_d = 1'b1;
                            shreg_d     = '0;
                            bit_cnt_d   = '0;
                        end
                        default: begin
                            err_timing_d = 1'b1;
                            shreg_d      = '0;
                            bit_cnt_d    = '0;
                        end
                    endcase
                end else if (width_q != {CNT_W{1'b1}}) begin
                    width_d = width_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            width_q      <= '0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            reset_det_q  <= 1'b0;
            err_timing_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            reset_det_q  <= reset_det_d;
            err_timing_q <= err_timing_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign reset_det  = reset_det_q;
    assign err_timing = err_timing_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_wired_bus_rx.sv
// Directed bench for wired_bus_rx: pulse-width stimulus with hand-computed bytes,
// a negedge monitor that logs each transaction, and per-scenario inline checks.
module tb_wired_bus_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_in = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       reset_det;
    logic       err_timing;
    logic       overrun;

    always #5 clk = ~clk;

    wired_bus_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .reset_det (reset_det),
        .err_timing(err_timing),
        .overrun   (overrun)
    );

    int checks = 0;
    int fails  = 0;

    int         n_rst = 0, n_err = 0, n_ovr = 0, n_vcyc = 0, n_acc = 0, n_multi = 0;
    logic [7:0] acc_mem [64];
    int         b_rst, b_err, b_ovr, b_vcyc, b_acc;

    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid) n_vcyc <= n_vcyc + 1;
            if (data_valid && data_ready) begin
                if (n_acc < 64) acc_mem[n_acc] <= data_out;
                n_acc <= n_acc + 1;
                $display("[%0t] accepted byte 0x%02h", $time, data_out);
            end
            if (reset_det) begin
                n_rst <= n_rst + 1;
                $display("[%0t] reset_det pulse", $time);
            end
            if (err_timing) begin
                n_err <= n_err + 1;
                $display("[%0t] err_timing pulse", $time);
            end
            if (overrun) begin
                n_ovr <= n_ovr + 1;
                $display("[%0t] overrun pulse, data_out=0x%02h", $time, data_out);
            end
            if (32'(reset_det) + 32'(err_timing) + 32'(overrun) > 1) n_multi <= n_multi + 1;
        end
    end

    task automatic snap();
        b_rst = n_rst; b_err = n_err; b_ovr = n_ovr; b_vcyc = n_vcyc; b_acc = n_acc;
    endtask

    task automatic drive_low(input int w);
        @(posedge clk); #2 bus_in = 1'b0;
        repeat (w) @(posedge clk);
        #2 bus_in = 1'b1;
    endtask

    task automatic gap(input int g);
        repeat (g) @(posedge clk);
    endtask

    task automatic send_bit(input logic v);
        drive_low(v ? 10 : 40);
        gap(20);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic check_deltas(input string name, input int d_rst, input int d_err,
                                input int d_ovr, input int d_acc);
        checks++;
        if ((n_rst - b_rst) !== d_rst || (n_err - b_err) !== d_err ||
            (n_ovr - b_ovr) !== d_ovr || (n_acc - b_acc) !== d_acc) begin
            fails++;
            $display("FAIL %s pulses: got rst=%0d err=%0d ovr=%0d acc=%0d, want rst=%0d err=%0d ovr=%0d acc=%0d",
                     name, n_rst - b_rst, n_err - b_err, n_ovr - b_ovr, n_acc - b_acc,
                     d_rst, d_err, d_ovr, d_acc);
        end
    endtask

    task automatic check_byte(input string name, input int idx, input logic [7:0] exp);
        checks++;
        if (idx >= 64 || idx >= n_acc) begin
            fails++;
            $display("FAIL %s: byte %0d never accepted, want 0x%02h", name, idx, exp);
        end else if (acc_mem[idx] !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", name, acc_mem[idx], exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (data_out !== 8'h00 || data_valid !== 1'b0 || reset_det !== 1'b0 ||
            err_timing !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL %s: got out=0x%02h v=%b rd=%b et=%b ov=%b, want all zero",
                     name, data_out, data_valid, reset_det, err_timing, overrun);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_held");
        @(posedge clk); #2 rst_n = 1'b1;
        gap(10);
        @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_byte_a5();
        data_ready = 1'b1;
        snap();
        send_byte(8'hA5);
        check_deltas("a5", 0, 0, 0, 1);
        check_byte("a5_value", b_acc, 8'hA5);
        checks++;
        if ((n_vcyc - b_vcyc) !== 1) begin
            fails++;
            $display("FAIL a5_valid_len: got %0d cycles, want 1", n_vcyc - b_vcyc);
        end
    endtask

    task automatic test_glitch();
        snap();
        drive_low(2);
        gap(20);
        check_deltas("glitch", 0, 0, 0, 0);
        send_byte(8'h5C);
        check_deltas("glitch_then_byte", 0, 0, 0, 1);
        check_byte("glitch_byte", b_acc, 8'h5C);
    endtask

    task automatic test_bus_reset();
        snap();
        drive_low(150);
        gap(20);
        check_deltas("bus_reset", 1, 0, 0, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        drive_low(150);
        gap(20);
        check_deltas("partial_reset", 2, 0, 0, 0);
        send_byte(8'h3C);
        check_deltas("after_reset_byte", 2, 0, 0, 1);
        check_byte("after_reset_3c", b_acc, 8'h3C);
    endtask

    task automatic test_timing_err();
        snap();
        drive_low(5);
        gap(20);
        check_deltas("min_width_bit", 0, 0, 0, 0);
        drive_low(90);
        gap(20);
        check_deltas("illegal_width", 0, 1, 0, 0);
        send_byte(8'hFF);
        send_byte(8'h01);
        check_deltas("after_err", 0, 1, 0, 2);
        check_byte("after_err_ff", b_acc, 8'hFF);
        check_byte("after_err_01", b_acc + 1, 8'h01);
    endtask

    task automatic test_overrun();
        logic [7:0] b33;
        b33 = 8'h33;
        @(posedge clk); #2 data_ready = 1'b0;
        snap();
        send_byte(8'h11);
        @(negedge clk);
        checks++;
        if (data_out !== 8'h11 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_11: got out=0x%02h v=%b, want 0x11 v=1", data_out, data_valid);
        end
        send_byte(8'h22);
        @(negedge clk);
        checks++;
        if (data_out !== 8'h11 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL overrun_keep: got out=0x%02h v=%b, want 0x11 v=1", data_out, data_valid);
        end
        check_deltas("overrun_pulse", 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) send_bit(b33[i]);
        drive_low(b33[7] ? 10 : 40);
        // Classification lands six edges after the raw rise; ready rises just before it.
        repeat (5) @(posedge clk);
        #2 data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (data_out !== 8'h33 || data_valid !== 1'b1) begin
            fails++;
            $display("FAIL accept_reload: got out=0x%02h v=%b, want 0x33 v=1", data_out, data_valid);
        end
        gap(10);
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_valid: got v=%b, want 0", data_valid);
        end
        check_deltas("overrun_total", 0, 0, 1, 2);
        check_byte("overrun_first", b_acc, 8'h11);
        check_byte("overrun_second", b_acc + 1, 8'h33);
    endtask

    task automatic test_async_reset();
        snap();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset_now");
        gap(3);
        @(posedge clk); #2 rst_n = 1'b1;
        gap(10);
        @(negedge clk);
        check_idle_outputs("async_reset_released");
        snap();
        send_byte(8'h5A);
        check_deltas("post_reset_byte", 0, 0, 0, 1);
        check_byte("post_reset_5a", b_acc, 8'h5A);
    endtask

    task automatic test_exclusive();
        checks++;
        if (n_multi !== 0) begin
            fails++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles, want 0", n_multi);
        end
    endtask

    initial begin
        test_reset();
        test_byte_a5();
        test_glitch();
        test_bus_reset();
        test_timing_err();
        test_overrun();
        test_async_reset();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
